one_two_demux_buf: RTL and testbench
====================================

Name: one_two_demux_buf

Overview:
- Buffered 1-to-2 demultiplexer: the inverse of the team's 2:1 mux.
- Accepts one W-bit word per handshake on input A and routes it to output channel Y0 (S=0) or Y1 (S=1).
- Each channel has its own small FIFO, so a stalled consumer on one channel never blocks traffic to the other.
- Sits between an operand source and two adder datapaths.

Parameters:
- W, 8, data width in bits (>=1)
- DEPTH, 2, entries per channel FIFO (power of 2, >=2)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- A  input  W  input data word
- A_VALID  input  1  input word present
- A_READY  output  1  block can accept a word for the channel selected by S
- S  input  1  channel select, sampled with A (0 -> Y0, 1 -> Y1)
- Y0  output  W  channel 0 head-of-FIFO data
- Y0_VALID  output  1  channel 0 FIFO non-empty
- Y0_READY  input  1  channel 0 consumer accepts
- Y1  output  W  channel 1 head-of-FIFO data
- Y1_VALID  output  1  channel 1 FIFO non-empty
- Y1_READY  input  1  channel 1 consumer accepts

Behaviour:
- Reset (async assert, sync-to-CLK release):
  - both FIFOs empty; Y0_VALID=Y1_VALID=0; Y0=Y1=0
  - A_READY=1 (both FIFOs empty)
- Accept: push occurs when A_VALID & A_READY at a rising CLK; the word is written to FIFO[S].
- A_READY (combinational from S and state only, never from A_VALID):
  - 1 when count of FIFO[S] < DEPTH
  - a pop on that same FIFO in the same cycle does NOT raise A_READY (no full-with-pop pass-through)
- Latency: a word accepted at edge n is visible on Yk with Yk_VALID=1 after edge n; no combinational path from A to Yk.
- Pop: when Yk_VALID & Yk_READY at an edge, the head advances.
  - Yk and Yk_VALID are driven from FIFO state only.
  - Yk holds its value while Yk_VALID & !Yk_READY.
- Simultaneous push and pop on the same non-full FIFO: count unchanged, data order preserved.
- Push to one channel and pop from the other in the same cycle: independent.
- Ordering: per channel strictly FIFO. No ordering guarantee across channels.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH.
- Count: log2(DEPTH)+1 bits, range 0..DEPTH.
- Yk when empty: holds the last value read (don't-care to consumers); reset value 0.
- S changing while A_VALID=1 and A_READY=0: legal. A_READY re-evaluates against the new S.
- Reset mid-transfer: all buffered words are discarded; outputs return to reset values immediately.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - adds outputs CNT0 and CNT1, 16 bits each: accepted-word counts per channel
  - increment on push to that channel; wrap 0xFFFF -> 0x0000
  - reset to 0 by RST
- Undefined: ports and counter logic absent; all other behaviour identical.

Decomposition:
- Shared package/header: default W and DEPTH constants; pointer width derived as log2(DEPTH).
- One natural sub-module, demux_chan_fifo: single-clock synchronous FIFO with push/pop/count/full/empty and head data. Instantiate it twice.
- Top level holds only the select and ready logic plus the optional counters.

Test Plan:
- Reset with A_VALID=1: during RST, Y0_VALID=Y1_VALID=0 and Y0=Y1=0. After release, A_READY=1 and no spurious push.
- Routing: push 0x11 with S=0, then 0x22 with S=1, with Y0_READY=Y1_READY=1 -> Y0=0x11 valid one cycle after its accept edge; Y1=0x22 likewise.
- Backpressure/full:
  - With Y0_READY=0, push 0xA1 and 0xA2 with S=0 -> A_READY=0 while S=0.
  - With S=1, A_READY=1 and a push of 0xB1 reaches Y1.
  - Then raise Y0_READY -> Y0 outputs 0xA1 then 0xA2.
- Full with simultaneous pop: FIFO0 full, Y0_READY=1, A_VALID=1, S=0 -> no accept that cycle, accept on the next cycle; sequence preserved.
- Wrap-around: stream 0x00..0x0F to channel 1 with Y1_READY toggling every cycle -> Y1 emits 0x00..0x0F in order, no loss or duplication.
- Mid-operation reset: FIFO0 holds 2 words, assert RST -> Y0_VALID=0 asynchronously. After release, the old words are never emitted. With DEMUX_CNT_EN defined, CNT0=CNT1=0.

Source files
------------

// File: rtl/one_two_demux_buf_pkg.sv
// Shared constants and types for the buffered 1-to-2 demultiplexer.
// Holds the default data width and FIFO depth, and the pointer-width helper.
package one_two_demux_buf_pkg;

  localparam int DEF_W     = 8;
  localparam int DEF_DEPTH = 2;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } chan_e;

  // Pointer width for a power-of-two depth; kept at least 1 bit wide.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/demux_chan_fifo.sv
// Single-clock channel FIFO with a registered head-of-queue output.
// The head register holds the last word read once the FIFO drains.
module demux_chan_fifo
  import one_two_demux_buf_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop_ready,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [W-1:0] mem [DEPTH];
  ptr_t         wr_ptr;
  ptr_t         rd_ptr;
  ptr_t         rd_nxt;
  cnt_t         count;
  logic         push_ok;
  logic         pop;

  assign valid   = (count != '0);
  assign full    = (count == cnt_t'(DEPTH));
  assign push_ok = push && !full;
  assign pop     = pop_ready && valid;
  assign rd_nxt  = rd_ptr + ptr_t'(1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + ptr_t'(1);
      if (pop)     rd_ptr <= rd_nxt;

      case ({push_ok, pop})
        2'b10:   count <= count + cnt_t'(1);
        2'b01:   count <= count - cnt_t'(1);
        default: count <= count;
      endcase

      // Head tracks the oldest word: load on first push, advance on pop,
      // and hold the last word read when the FIFO empties.
      if (push_ok && !valid)
        head <= din;
      else if (pop && (count != cnt_t'(1)))
        head <= mem[rd_nxt];
      else if (pop && push_ok)
        head <= din;
    end
  end

  // NOTE: the storage array has no reset; validity is carried entirely by
  // count, so clearing it would only cost reset routing.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/one_two_demux_buf.sv
// Buffered 1-to-2 demux: routes A to channel Y0/Y1 by S through per-channel FIFOs.
// Optional macro DEMUX_CNT_EN adds 16-bit accepted-word counters CNT0/CNT1.
module one_two_demux_buf
  import one_two_demux_buf_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic [W-1:0] A,
  input  logic         A_VALID,
  output logic         A_READY,
  input  logic         S,
  output logic [W-1:0] Y0,
  output logic         Y0_VALID,
  input  logic         Y0_READY,
  output logic [W-1:0] Y1,
  output logic         Y1_VALID,
  input  logic         Y1_READY
`ifdef DEMUX_CNT_EN
  ,
  output logic [15:0]  CNT0,
  output logic [15:0]  CNT1
`endif
);

  chan_e sel;
  logic  full0;
  logic  full1;
  logic  push0;
  logic  push1;

  // Ready depends only on the selected FIFO's fill state, never on A_VALID
  // or on a same-cycle pop.
  assign sel     = chan_e'(S);
  assign A_READY = (sel == CH1) ? !full1 : !full0;
  assign push0   = A_VALID && A_READY && (sel == CH0);
  assign push1   = A_VALID && A_READY && (sel == CH1);

  demux_chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (CLK),
    .rst       (RST),
    .push      (push0),
    .din       (A),
    .pop_ready (Y0_READY),
    .head      (Y0),
    .valid     (Y0_VALID),
    .full      (full0)
  );

  demux_chan_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (CLK),
    .rst       (RST),
    .push      (push1),
    .din       (A),
    .pop_ready (Y1_READY),
    .head      (Y1),
    .valid     (Y1_VALID),
    .full      (full1)
  );

`ifdef DEMUX_CNT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      CNT0 <= '0;
      CNT1 <= '0;
    end else begin
      if (push0) CNT0 <= CNT0 + 16'd1;
      if (push1) CNT1 <= CNT1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_one_two_demux_buf.sv
// Self-checking bench for one_two_demux_buf: scoreboard queues per channel
// are filled on accepted handshakes and drained on observed pops.
module tb_one_two_demux_buf;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] A;
  logic       A_VALID;
  logic       A_READY;
  logic       S;
  logic [7:0] Y0;
  logic       Y0_VALID;
  logic       Y0_READY;
  logic [7:0] Y1;
  logic       Y1_VALID;
  logic       Y1_READY;
`ifdef DEMUX_CNT_EN
  logic [15:0] CNT0;
  logic [15:0] CNT1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int pops0       = 0;
  int pops1       = 0;
  int acc0        = 0;
  int acc1        = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];

  one_two_demux_buf #(.W(8), .DEPTH(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .A        (A),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .S        (S),
    .Y0       (Y0),
    .Y0_VALID (Y0_VALID),
    .Y0_READY (Y0_READY),
    .Y1       (Y1),
    .Y1_VALID (Y1_VALID),
    .Y1_READY (Y1_READY)
`ifdef DEMUX_CNT_EN
    ,
    .CNT0     (CNT0),
    .CNT1     (CNT1)
`endif
  );

  always #5 CLK = ~CLK;

  // Scoreboard monitor: samples on the falling edge, mid-cycle.
  always @(negedge CLK) begin
    if (!RST) begin
      if (Y0_VALID && Y0_READY) begin
        pops0++;
        vectors++;
        if (q0.size() == 0) begin
          miscompares++;
          $display("FAIL y0_pop: got %02h with no word expected", Y0);
        end else begin
          logic [7:0] e0;
          e0 = q0.pop_front();
          if (Y0 !== e0) begin
            miscompares++;
            $display("FAIL y0_pop: got %02h expected %02h", Y0, e0);
          end
        end
      end
      if (Y1_VALID && Y1_READY) begin
        pops1++;
        vectors++;
        if (q1.size() == 0) begin
          miscompares++;
          $display("FAIL y1_pop: got %02h with no word expected", Y1);
        end else begin
          logic [7:0] e1;
          e1 = q1.pop_front();
          if (Y1 !== e1) begin
            miscompares++;
            $display("FAIL y1_pop: got %02h expected %02h", Y1, e1);
          end
        end
      end
      if (A_VALID && A_READY) begin
        if (S) begin q1.push_back(A); acc1++; end
        else   begin q0.push_back(A); acc0++; end
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; A_VALID = 1'b1; A = 8'h55; S = 1'b0;
    Y0_READY = 1'b0; Y1_READY = 1'b0;
    cyc(); cyc();
    vectors++;
    if (Y0_VALID !== 1'b0 || Y1_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_valid: got %b/%b expected 0/0", Y0_VALID, Y1_VALID);
    end
    vectors++;
    if (Y0 !== 8'h00 || Y1 !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_data: got %02h/%02h expected 00/00", Y0, Y1);
    end
    RST = 1'b0; A_VALID = 1'b0;
    cyc();
    vectors++;
    if (A_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_a_ready: got %b expected 1", A_READY);
    end
    vectors++;
    if (Y0_VALID !== 1'b0 || Y1_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_push: got %b/%b expected 0/0", Y0_VALID, Y1_VALID);
    end
  endtask

  task automatic test_routing();
    Y0_READY = 1'b1; Y1_READY = 1'b1;
    A = 8'h11; S = 1'b0; A_VALID = 1'b1;
    #1;
    vectors++;
    if (A_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL route_ready: got %b expected 1", A_READY);
    end
    cyc();
    A = 8'h22; S = 1'b1;
    vectors++;
    if (Y0_VALID !== 1'b1 || Y0 !== 8'h11) begin
      miscompares++;
      $display("FAIL route_y0: got %b/%02h expected 1/11", Y0_VALID, Y0);
    end
    cyc();
    A_VALID = 1'b0;
    vectors++;
    if (Y1_VALID !== 1'b1 || Y1 !== 8'h22 || Y0_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL route_y1: got %b/%02h y0v=%b expected 1/22 y0v=0", Y1_VALID, Y1, Y0_VALID);
    end
    cyc();
    vectors++;
    if (Y1_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL route_drain: got %b expected 0", Y1_VALID);
    end
  endtask

  task automatic test_backpressure();
    Y0_READY = 1'b0; Y1_READY = 1'b1;
    S = 1'b0; A_VALID = 1'b1; A = 8'hA1;
    cyc();
    A = 8'hA2;
    cyc();
    A = 8'hA3;
    #1;
    vectors++;
    if (A_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_full_ready: got %b expected 0", A_READY);
    end
    cyc();
    vectors++;
    if (Y0_VALID !== 1'b1 || Y0 !== 8'hA1) begin
      miscompares++;
      $display("FAIL bp_hold: got %b/%02h expected 1/a1", Y0_VALID, Y0);
    end
    S = 1'b1; A = 8'hB1;
    #1;
    vectors++;
    if (A_READY !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_other_ready: got %b expected 1", A_READY);
    end
    cyc();
    A_VALID = 1'b0;
    vectors++;
    if (Y1_VALID !== 1'b1 || Y1 !== 8'hB1) begin
      miscompares++;
      $display("FAIL bp_y1: got %b/%02h expected 1/b1", Y1_VALID, Y1);
    end
    cyc();
    Y0_READY = 1'b1;
    #1;
    vectors++;
    if (Y0 !== 8'hA1) begin
      miscompares++;
      $display("FAIL bp_first: got %02h expected a1", Y0);
    end
    cyc();
    vectors++;
    if (Y0_VALID !== 1'b1 || Y0 !== 8'hA2) begin
      miscompares++;
      $display("FAIL bp_second: got %b/%02h expected 1/a2", Y0_VALID, Y0);
    end
    cyc();
    vectors++;
    if (Y0_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got %b expected 0", Y0_VALID);
    end
  endtask

  task automatic test_full_pop();
    Y0_READY = 1'b0; S = 1'b0; A_VALID = 1'b1; A = 8'hC1;
    cyc();
    A = 8'hC2;
    cyc();
    A = 8'hC3; Y0_READY = 1'b1;
    #1;
    vectors++;
    if (A_READY !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_no_pass: got %b expected 0", A_READY);
    end
    cyc();
    vectors++;
    if (A_READY !== 1'b1 || Y0 !== 8'hC2) begin
      miscompares++;
      $display("FAIL fp_after_pop: got rdy=%b y0=%02h expected rdy=1 y0=c2", A_READY, Y0);
    end
    cyc();
    A_VALID = 1'b0;
    vectors++;
    if (Y0_VALID !== 1'b1 || Y0 !== 8'hC3) begin
      miscompares++;
      $display("FAIL fp_order: got %b/%02h expected 1/c3", Y0_VALID, Y0);
    end
    cyc();
    vectors++;
    if (Y0_VALID !== 1'b0) begin
      miscompares++;
      $display("FAIL fp_drain: got %b expected 0", Y0_VALID);
    end
  endtask

  task automatic test_wrap();
    int sent    = 0;
    int budget  = 0;
    int p_start = pops1;
    logic acc;
    Y0_READY = 1'b0; Y1_READY = 1'b0; S = 1'b1; A_VALID = 1'b1;
    while (sent < 16 && budget < 200) begin
      A = 8'(sent);
      Y1_READY = ~Y1_READY;
      #1;
      acc = A_READY;
      cyc();
      if (acc) sent++;
      budget++;
    end
    A_VALID = 1'b0; Y1_READY = 1'b1;
    vectors++;
    if (sent != 16) begin
      miscompares++;
      $display("FAIL wrap_send: got %0d words sent expected 16", sent);
    end
    for (int i = 0; i < 20 && Y1_VALID; i++) cyc();
    vectors++;
    if (Y1_VALID !== 1'b0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL wrap_drain: got valid=%b left=%0d expected 0/0", Y1_VALID, q1.size());
    end
    vectors++;
    if (pops1 - p_start != 16) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d pops expected 16", pops1 - p_start);
    end
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    vectors++;
    if (CNT0 !== 16'(acc0) || CNT1 !== 16'(acc1)) begin
      miscompares++;
      $display("FAIL cnt_val: got %0d/%0d expected %0d/%0d", CNT0, CNT1, acc0, acc1);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int p_start;
    Y0_READY = 1'b0; S = 1'b0; A_VALID = 1'b1; A = 8'hD1;
    cyc();
    A = 8'hD2;
    cyc();
    A_VALID = 1'b0;
    vectors++;
    if (Y0_VALID !== 1'b1) begin
      miscompares++;
      $display("FAIL mr_loaded: got %b expected 1", Y0_VALID);
    end
    #2;
    RST = 1'b1;
    #1;
    vectors++;
    if (Y0_VALID !== 1'b0 || Y0 !== 8'h00) begin
      miscompares++;
      $display("FAIL mr_async: got %b/%02h expected 0/00", Y0_VALID, Y0);
    end
    q0.delete(); q1.delete();
    acc0 = 0; acc1 = 0;
    cyc(); cyc();
    RST = 1'b0; Y0_READY = 1'b1;
    p_start = pops0;
    repeat (5) cyc();
    vectors++;
    if (Y0_VALID !== 1'b0 || pops0 != p_start) begin
      miscompares++;
      $display("FAIL mr_discard: got valid=%b pops=%0d expected 0/0", Y0_VALID, pops0 - p_start);
    end
`ifdef DEMUX_CNT_EN
    vectors++;
    if (CNT0 !== 16'd0 || CNT1 !== 16'd0) begin
      miscompares++;
      $display("FAIL mr_cnt: got %0d/%0d expected 0/0", CNT0, CNT1);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_full_pop();
    test_wrap();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    test_mid_reset();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover: got %0d/%0d words pending expected 0/0", q0.size(), q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
